alu_exec_stage: RTL
===================

# alu_exec_stage

Issue/writeback stage wrapped around the combinational ALU. It accepts one instruction per cycle over a valid/ready handshake and reads operands from an 8-entry x 8-bit register file, or from an immediate. It registers the opcode and operands into an execute (EX) register that drives the ALU, then writes the ALU result and flags back on the following edge. It forwards an in-flight result to a dependent instruction, so back-to-back dependent instructions issue without stalls.

## Interface
- NREGS, 8, number of general registers; register address width is clog2(NREGS) = 3.
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  instruction offered.
- in_ready  out  1  stage can accept; equals ~hold.
- in_op  in  4  ALU opcode, `OP_* encoding from defines.vh, passed through unmodified.
- in_rd, in_rs1, in_rs2  in  3 each  destination / source register addresses.
- in_imm  in  8  immediate operand.
- in_use_imm  in  1  1: operand2 = in_imm, 0: operand2 = reg[in_rs2].
- in_wb  in  1  1: write result to rd; 0: flags only (compare/test).
- hold  in  1  freezes the stage (no accept, no writeback).
- alu_operation  out  4  to ALU operation.
- alu_operand1, alu_operand2  out  8 each  to ALU.
- alu_result  in  8; alu_zero, alu_overflow, alu_carry, alu_negative  in  1 each  from ALU.
- flags  out  4  status register {N, C, V, Z}.
- retire_valid  out  1  registered pulse, one cycle after a writeback edge.
- retire_rd  out  3; retire_data  out  8  rd and result of the retired instruction.
- dbg_raddr  in  3; dbg_rdata  out  8  combinational read port of the register file.

## Operation
- Accept: in_valid & in_ready at an edge loads EX from the decoded fields: ex_valid=1, ex_op, ex_a, ex_b, ex_rd, ex_wb. Without accept (and ~hold), ex_valid clears to 0; the other EX fields keep their values.
- ALU ports are driven directly from EX registers (alu_operation=ex_op, operand1=ex_a, operand2=ex_b), regardless of ex_valid.
- Writeback at an edge with ex_valid & ~hold:
  - flags <= {alu_negative, alu_carry, alu_overflow, alu_zero}.
  - If ex_wb, reg[ex_rd] <= alu_result.
  - retire_valid <= 1; retire_rd, retire_data latched.
- Otherwise retire_valid <= 0.
- Forwarding at accept: if ex_valid & ex_wb & (ex_rd == in_rs1), operand1 takes alu_result instead of reg[in_rs1]. Same rule for rs2 when ~in_use_imm. Forwarding takes priority over the register file.
- Register 0 is an ordinary writable register (not hardwired).
- hold=1: EX, register file, flags frozen; retire_valid <= 0; in_ready=0.
- Undefined opcodes are passed through; the ALU yields result 0, and Z=1 is written like any other result.

## Timing
- Reset (async, immediate): all registers 0, flags 0, ex_valid 0, EX fields 0 (so alu_operation/operands read 0), retire_valid 0, retire_rd/data 0.
- Latency: accept at edge N; ALU evaluates during cycle N..N+1; reg/flags written at edge N+1; visible on dbg_rdata and flags after edge N+1; retire_valid high for the cycle after edge N+1.
- Throughput: 1 instruction/cycle while hold=0.
- Simultaneous writeback of rX and accept reading rX at the same edge: forwarded value used (never stale).
- Hold released: the held EX instruction writes back at the first edge with hold=0.
- Reset asserted mid-instruction: the in-flight instruction is discarded; no writeback.

## Test plan
- Reset → flags=0, dbg_rdata=0 for all addresses, retire_valid=0, in_ready=1 after reset deassertion.
- Issue OR r1=r0|imm 0x05, then OR r2=r0|imm 0xFB, then ADD r3=r1+r2 on consecutive cycles → r3=0x00, flags Z=1,C=1,V=0,N=0; retire pulses on 3 consecutive cycles.
- Back-to-back dependency chain: ADD r1=r1+imm 1 four times from r1=0 → r1=4, each using the forwarded value.
- SUB r4 = 0x80 - 0x01 with in_wb=0 → r4 unchanged, flags V=1, N=0, C=1; retire_rd=4, retire_data=0x7F.
- hold=1 for 3 cycles with instruction in EX → no reg/flag change, in_ready=0, retire_valid=0; single writeback on release.
- Assert rst one cycle after accept of ADD r5 → r5=0 and flags=0 after reset; no retire pulse.

Source files
------------

// File: rtl/alu_exec_stage.sv
// rtl/alu_exec_stage.sv - issue/writeback stage around the combinational ALU
// One EX register feeds the ALU; results forward to the next issued instruction.
module alu_exec_stage #(
  parameter int NREGS = 8,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [3:0]    in_op,
  input  logic [AW-1:0] in_rd,
  input  logic [AW-1:0] in_rs1,
  input  logic [AW-1:0] in_rs2,
  input  logic [7:0]    in_imm,
  input  logic          in_use_imm,
  input  logic          in_wb,
  input  logic          hold,
  output logic [3:0]    alu_operation,
  output logic [7:0]    alu_operand1,
  output logic [7:0]    alu_operand2,
  input  logic [7:0]    alu_result,
  input  logic          alu_zero,
  input  logic          alu_overflow,
  input  logic          alu_carry,
  input  logic          alu_negative,
  output logic [3:0]    flags,
  output logic          retire_valid,
  output logic [AW-1:0] retire_rd,
  output logic [7:0]    retire_data,
  input  logic [AW-1:0] dbg_raddr,
  output logic [7:0]    dbg_rdata
);

  logic [7:0]    regs_q [NREGS];
  logic [7:0]    regs_d [NREGS];
  logic          ex_valid_q, ex_valid_d;
  logic [3:0]    ex_op_q, ex_op_d;
  logic [7:0]    ex_a_q, ex_a_d;
  logic [7:0]    ex_b_q, ex_b_d;
  logic [AW-1:0] ex_rd_q, ex_rd_d;
  logic          ex_wb_q, ex_wb_d;
  logic [3:0]    flags_q, flags_d;
  logic          retire_valid_q, retire_valid_d;
  logic [AW-1:0] retire_rd_q, retire_rd_d;
  logic [7:0]    retire_data_q, retire_data_d;

  logic          accept;
  logic          fwd1, fwd2;
  logic [7:0]    op1, op2;

  assign in_ready      = ~hold;
  assign accept        = in_valid & ~hold;
  assign alu_operation = ex_op_q;
  assign alu_operand1  = ex_a_q;
  assign alu_operand2  = ex_b_q;
  assign flags         = flags_q;
  assign retire_valid  = retire_valid_q;
  assign retire_rd     = retire_rd_q;
  assign retire_data   = retire_data_q;
  assign dbg_rdata     = regs_q[dbg_raddr];

  // The instruction in EX writes back on the same edge this one is accepted,
  // so its ALU result must bypass the register file.
  assign fwd1 = ex_valid_q & ex_wb_q & (ex_rd_q == in_rs1);
  assign fwd2 = ex_valid_q & ex_wb_q & (ex_rd_q == in_rs2);
  assign op1  = fwd1 ? alu_result : regs_q[in_rs1];
  assign op2  = in_use_imm ? in_imm : (fwd2 ? alu_result : regs_q[in_rs2]);

  always_comb begin
    regs_d         = regs_q;
    ex_valid_d     = ex_valid_q;
    ex_op_d        = ex_op_q;
    ex_a_d         = ex_a_q;
    ex_b_d         = ex_b_q;
    ex_rd_d        = ex_rd_q;
    ex_wb_d        = ex_wb_q;
    flags_d        = flags_q;
    retire_valid_d = 1'b0;
    retire_rd_d    = retire_rd_q;
    retire_data_d  = retire_data_q;
    if (!hold) begin
      ex_valid_d = accept;
      if (accept) begin
        ex_op_d = in_op;
        ex_a_d  = op1;
        ex_b_d  = op2;
        ex_rd_d = in_rd;
        ex_wb_d = in_wb;
      end
      if (ex_valid_q) begin
        flags_d        = {alu_negative, alu_carry, alu_overflow, alu_zero};
        retire_valid_d = 1'b1;
        retire_rd_d    = ex_rd_q;
        retire_data_d  = alu_result;
        if (ex_wb_q) regs_d[ex_rd_q] = alu_result;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= 8'h00;
      ex_valid_q     <= 1'b0;
      ex_op_q        <= 4'h0;
      ex_a_q         <= 8'h00;
      ex_b_q         <= 8'h00;
      ex_rd_q        <= '0;
      ex_wb_q        <= 1'b0;
      flags_q        <= 4'h0;
      retire_valid_q <= 1'b0;
      retire_rd_q    <= '0;
      retire_data_q  <= 8'h00;
    end else begin
      regs_q         <= regs_d;
      ex_valid_q     <= ex_valid_d;
      ex_op_q        <= ex_op_d;
      ex_a_q         <= ex_a_d;
      ex_b_q         <= ex_b_d;
      ex_rd_q        <= ex_rd_d;
      ex_wb_q        <= ex_wb_d;
      flags_q        <= flags_d;
      retire_valid_q <= retire_valid_d;
      retire_rd_q    <= retire_rd_d;
      retire_data_q  <= retire_data_d;
    end
  end

endmodule
